vga_box_mixer: RTL and testbench



---
 rtl/vga_box_mixer_pkg.sv | 40 ++++
 rtl/vga_box_mover.sv | 78 +++++++
 rtl/vga_box_mixer.sv | 144 ++++++++++++++
 tb/tb_vga_box_mixer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_box_mixer_pkg.sv
// rtl/vga_box_mixer_pkg.sv - shared mode encodings, LFSR step and colour-byte helpers
// Colour byte layout used everywhere: B = [7:6], G = [5:3], R = [2:0].
package vga_box_mixer_pkg;

    typedef enum logic [1:0] {
        MIX_BLACK      = 2'd0,
        MIX_NOISE      = 2'd1,
        MIX_GRAD       = 2'd2,
        MIX_NOISE_ONLY = 2'd3
    } mix_mode_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // Galois right-shift step; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Low byte of v rotated right by sh bits.
    function automatic logic [7:0] rot_byte(input logic [15:0] v, input int unsigned sh);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b] = v[4'((int'(sh) + b) % 16)];
        end
        return r;
    endfunction

    function automatic logic [2:0] col_r(input logic [7:0] c);
        return c[2:0];
    endfunction

    function automatic logic [2:0] col_g(input logic [7:0] c);
        return c[5:3];
    endfunction

    function automatic logic [1:0] col_b(input logic [7:0] c);
        return c[7:6];
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - one bouncing box: position/direction/colour state and hit test
// Ports: clk, rst_n (async, active-low); update (frame tick, not paused);
// lfsr (colour source); loc_x/loc_y (pixel under test); hit (combinational); colour.
module vga_box_mover
    import vga_box_mixer_pkg::*;
#(
    parameter int IDX     = 0,
    parameter int NUM_BOX = 2,
    parameter int RES_H   = 1280,
    parameter int RES_V   = 720,
    parameter int BOX_W   = 128,
    parameter int BOX_H   = 96,
    parameter int STEP    = 4,
    parameter int COORD_W = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               update,
    input  logic [15:0]        lfsr,
    input  logic [COORD_W-1:0] loc_x,
    input  logic [COORD_W-1:0] loc_y,
    output logic               hit,
    output logic [7:0]         colour
);

    localparam int CW1 = COORD_W + 1;

    localparam logic [COORD_W-1:0] X0     = COORD_W'(IDX * (RES_H / NUM_BOX));
    localparam logic [COORD_W-1:0] Y0     = COORD_W'(IDX * (RES_V / (2 * NUM_BOX)));
    localparam logic [7:0]         C0     = 8'hFF >> IDX;
    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(STEP);
    localparam logic [CW1-1:0]     STEP_E = CW1'(STEP);
    localparam logic [CW1-1:0]     BW_E   = CW1'(BOX_W);
    localparam logic [CW1-1:0]     BH_E   = CW1'(BOX_H);
    // p + STEP + SIZE >= RES  is rewritten as  p + STEP >= RES - SIZE.
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(RES_H - BOX_W);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(RES_V - BOX_H);
    localparam logic [CW1-1:0]     X_LIM  = CW1'(RES_H - BOX_W);
    localparam logic [CW1-1:0]     Y_LIM  = CW1'(RES_V - BOX_H);

    logic [COORD_W-1:0] x, y;
    logic               dir_x, dir_y;   // 1 = moving towards larger coordinates

    // Returns {new_dir, new_pos}; clamps to the wall and reverses on contact.
    function automatic logic [COORD_W:0] bounce(input logic [COORD_W-1:0] p,
                                                input logic               d,
                                                input logic [CW1-1:0]     lim,
                                                input logic [COORD_W-1:0] pmax);
        if (d) begin
            if ({1'b0, p} + STEP_E >= lim) begin
                return {1'b0, pmax};
            end
            return {1'b1, p + STEP_C};
        end
        if (p < STEP_C) begin
            return {1'b1, {COORD_W{1'b0}}};
        end
        return {1'b0, p - STEP_C};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= X0;
            y      <= Y0;
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            colour <= C0;
        end else if (update) begin
            {dir_x, x} <= bounce(x, dir_x, X_LIM, X_MAX);
            {dir_y, y} <= bounce(y, dir_y, Y_LIM, Y_MAX);
            colour     <= rot_byte(lfsr, 3 * IDX);
        end
    end

    assign hit = (loc_x >= x) && ({1'b0, loc_x} < {1'b0, x} + BW_E) &&
                 (loc_y >= y) && ({1'b0, loc_y} < {1'b0, y} + BH_E);

endmodule

// File: rtl/vga_box_mixer.sv
// rtl/vga_box_mixer.sv - bouncing-box compositor between vga_sync and the VGA pins
// Ports: PIXEL_CLK, RST_N (async, active-low); locX/locY, in_image, sync_h, sync_v
// from vga_sync; MODE (background), PAUSE (freeze boxes); vgaRed/vgaGreen/vgaBlue
// and Hsync/Vsync, all two cycles behind their inputs.
module vga_box_mixer
    import vga_box_mixer_pkg::*;
#(
    parameter int          RES_H   = 1280,
    parameter int          RES_V   = 720,
    parameter int          COORD_W = 13,
    parameter int          NUM_BOX = 2,
    parameter int          BOX_W   = 128,
    parameter int          BOX_H   = 96,
    parameter int          STEP    = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               PIXEL_CLK,
    input  logic               RST_N,
    input  logic [COORD_W-1:0] locX,
    input  logic [COORD_W-1:0] locY,
    input  logic               in_image,
    input  logic               sync_h,
    input  logic               sync_v,
    input  logic [1:0]         MODE,
    input  logic               PAUSE,
    output logic [2:0]         vgaRed,
    output logic [2:0]         vgaGreen,
    output logic [1:0]         vgaBlue,
    output logic               Hsync,
    output logic               Vsync
);

    logic [15:0]        lfsr;
    logic               sync_v_q;
    logic               tick;
    logic [NUM_BOX-1:0] hit_vec;
    logic [7:0]         box_col [NUM_BOX];
    mix_mode_t          mode;
    logic [NUM_BOX-1:0] hit_mask;
    logic [7:0]         pick_col;
    logic [7:0]         bg_col;

    logic [NUM_BOX-1:0] s1_hit;
    logic [7:0]         s1_col;
    logic [7:0]         s1_bg;
    logic               s1_img, s1_hs, s1_vs;
    logic [7:0]         pix;

    assign mode = mix_mode_t'(MODE);
    assign tick = sync_v & ~sync_v_q;

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            lfsr     <= SEED;
            sync_v_q <= 1'b0;
        end else begin
            lfsr     <= lfsr_next(lfsr);
            sync_v_q <= sync_v;
        end
    end

    for (genvar i = 0; i < NUM_BOX; i++) begin : g_box
        vga_box_mover #(
            .IDX(i), .NUM_BOX(NUM_BOX), .RES_H(RES_H), .RES_V(RES_V),
            .BOX_W(BOX_W), .BOX_H(BOX_H), .STEP(STEP), .COORD_W(COORD_W)
        ) u_mover (
            .clk    (PIXEL_CLK),
            .rst_n  (RST_N),
            .update (tick & ~PAUSE),
            .lfsr   (lfsr),
            .loc_x  (locX),
            .loc_y  (locY),
            .hit    (hit_vec[i]),
            .colour (box_col[i])
        );
    end

    // Highest index is visited first so the lowest-index hit overwrites it.
    always_comb begin
        hit_mask = (mode == MIX_NOISE_ONLY) ? '0 : hit_vec;
        pick_col = 8'h00;
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            if (hit_mask[i]) begin
                pick_col = box_col[i];
            end
        end
    end

    // Gradient needs COORD_W >= 10 for locX[9:8].
    always_comb begin
        bg_col = 8'h00;
        case (mode)
            MIX_BLACK:      bg_col = 8'h00;
            MIX_GRAD:       bg_col = {locX[9:8], locY[7:5], locX[7:5]};
            MIX_NOISE,
            MIX_NOISE_ONLY: bg_col = {{2{lfsr[2]}}, {3{lfsr[1]}}, {3{lfsr[0]}}};
            default:        bg_col = 8'h00;
        endcase
    end

    // The winning box colour is captured with the hit so a colour update on the
    // tick edge cannot split a pixel between old and new state.
    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_hit <= '0;
            s1_col <= 8'h00;
            s1_bg  <= 8'h00;
            s1_img <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
        end else begin
            s1_hit <= hit_mask;
            s1_col <= pick_col;
            s1_bg  <= bg_col;
            s1_img <= in_image;
            s1_hs  <= sync_h;
            s1_vs  <= sync_v;
        end
    end

    always_comb begin
        pix = 8'h00;
        if (s1_img) begin
            pix = (|s1_hit) ? s1_col : s1_bg;
        end
    end

    always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
        if (!RST_N) begin
            vgaRed   <= 3'd0;
            vgaGreen <= 3'd0;
            vgaBlue  <= 2'd0;
            Hsync    <= 1'b0;
            Vsync    <= 1'b0;
        end else begin
            vgaRed   <= col_r(pix);
            vgaGreen <= col_g(pix);
            vgaBlue  <= col_b(pix);
            Hsync    <= s1_hs;
            Vsync    <= s1_vs;
        end
    end

endmodule

// File: tb/tb_vga_box_mixer.sv
// tb/tb_vga_box_mixer.sv - self-checking bench for vga_box_mixer on a small screen
module tb_vga_box_mixer;

    localparam int          RH   = 160;
    localparam int          RV   = 120;
    localparam int          BW   = 32;
    localparam int          BH   = 24;
    localparam int          ST   = 4;
    localparam int          NB   = 2;
    localparam int          CW   = 13;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] loc_x = '0, loc_y = '0;
    logic          in_image = 1'b0, sync_h = 1'b0, sync_v = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          pause = 1'b0;
    logic [2:0]    vga_r, vga_g;
    logic [1:0]    vga_b;
    logic          hsync, vsync;

    always #5 clk = ~clk;

    vga_box_mixer #(
        .RES_H(RH), .RES_V(RV), .COORD_W(CW), .NUM_BOX(NB),
        .BOX_W(BW), .BOX_H(BH), .STEP(ST), .SEED(SEED)
    ) dut (
        .PIXEL_CLK (clk),
        .RST_N     (rst_n),
        .locX      (loc_x),
        .locY      (loc_y),
        .in_image  (in_image),
        .sync_h    (sync_h),
        .sync_v    (sync_v),
        .MODE      (mode),
        .PAUSE     (pause),
        .vgaRed    (vga_r),
        .vgaGreen  (vga_g),
        .vgaBlue   (vga_b),
        .Hsync     (hsync),
        .Vsync     (vsync)
    );

    typedef struct {
        logic        chk;
        logic [7:0]  rgb;   // {R[2:0], G[2:0], B[1:0]}
        logic        hs;
        logic        vs;
        logic [63:0] tag;
        int          id;
    } exp_t;

    typedef struct {
        logic          img;
        logic [CW-1:0] x, y;
        logic          hs;
        logic [1:0]    md;
        logic [7:0]    rgb;
    } vec_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   seq_id = 0;

    // Reference state of the boxes and LFSR, advanced once per clock.
    int          mx [NB];
    int          my [NB];
    bit          mdx [NB];
    bit          mdy [NB];
    logic [7:0]  mcol [NB];
    logic [15:0] mlfsr;
    bit          msv_q;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]   = i * (RH / NB);
            my[i]   = i * (RV / (2 * NB));
            mdx[i]  = 1'b1;
            mdy[i]  = 1'b1;
            mcol[i] = 8'hFF >> i;
        end
        mlfsr = SEED;
        msv_q = 1'b0;
    endtask

    task automatic bounce(input int p_in, input bit d_in, input int sz, input int lim,
                          output int p, output bit d);
        p = p_in;
        d = d_in;
        if (d_in) begin
            if (p_in + ST + sz >= lim) begin
                p = lim - sz;
                d = 1'b0;
            end else begin
                p = p_in + ST;
            end
        end else begin
            if (p_in < ST) begin
                p = 0;
                d = 1'b1;
            end else begin
                p = p_in - ST;
            end
        end
    endtask

    task automatic model_step(input logic sv, input logic pz);
        int          p;
        bit          d;
        logic [15:0] rot;
        if (sv && !msv_q && !pz) begin
            for (int i = 0; i < NB; i++) begin
                bounce(mx[i], mdx[i], BW, RH, p, d);
                mx[i] = p;
                mdx[i] = d;
                bounce(my[i], mdy[i], BH, RV, p, d);
                my[i] = p;
                mdy[i] = d;
                rot = (mlfsr >> (3 * i)) | (mlfsr << (16 - 3 * i));
                mcol[i] = rot[7:0];
            end
        end
        mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
        msv_q = sv;
    endtask

    function automatic logic [7:0] model_rgb(input logic img, input logic [CW-1:0] x,
                                             input logic [CW-1:0] y, input logic [1:0] md);
        logic [2:0] r, g;
        logic [1:0] b;
        logic [7:0] c;
        bit         hit;
        if (!img) return 8'h00;
        hit = 1'b0;
        c = 8'h00;
        if (md != 2'd3) begin
            for (int i = NB - 1; i >= 0; i--) begin
                if (int'(x) >= mx[i] && int'(x) < mx[i] + BW &&
                    int'(y) >= my[i] && int'(y) < my[i] + BH) begin
                    hit = 1'b1;
                    c = mcol[i];
                end
            end
        end
        if (hit) begin
            r = c[2:0];
            g = c[5:3];
            b = c[7:6];
        end else begin
            case (md)
                2'd0:    begin r = 3'd0;        g = 3'd0;        b = 2'd0;          end
                2'd2:    begin r = x[7:5];      g = y[7:5];      b = x[9:8];        end
                default: begin r = {3{mlfsr[0]}}; g = {3{mlfsr[1]}}; b = {2{mlfsr[2]}}; end
            endcase
        end
        return {r, g, b};
    endfunction

    // One pixel clock: check the output due now, drive a new vector, queue its expectation.
    task automatic drive_push(input logic img, input logic [CW-1:0] x, input logic [CW-1:0] y,
                              input logic hs, input logic vs, input logic [1:0] md,
                              input logic pz, input exp_t e);
        exp_t got;
        @(negedge clk);
        if (q.size() == 2) begin
            got = q.pop_front();
            if (got.chk) begin
                n_vec++;
                if ({vga_r, vga_g, vga_b} !== got.rgb || hsync !== got.hs || vsync !== got.vs) begin
                    n_err++;
                    $display("FAIL %0s #%0d: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             got.tag, got.id, {vga_r, vga_g, vga_b}, hsync, vsync,
                             got.rgb, got.hs, got.vs);
                end
            end
        end
        in_image = img;
        loc_x    = x;
        loc_y    = y;
        sync_h   = hs;
        sync_v   = vs;
        mode     = md;
        pause    = pz;
        q.push_back(e);
        model_step(vs, pz);
    endtask

    task automatic cycle(input logic img, input logic [CW-1:0] x, input logic [CW-1:0] y,
                         input logic hs, input logic vs, input logic [1:0] md,
                         input logic pz, input logic chk, input logic [63:0] tag);
        exp_t e;
        e.chk = chk;
        e.rgb = model_rgb(img, x, y, md);
        e.hs  = hs;
        e.vs  = vs;
        e.tag = tag;
        e.id  = seq_id++;
        drive_push(img, x, y, hs, vs, md, pz, e);
    endtask

    task automatic do_reset();
        exp_t z;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({vga_r, vga_g, vga_b, hsync, vsync} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_out: outputs=%h, expected 000", {vga_r, vga_g, vga_b, hsync, vsync});
        end
        in_image = 1'b0;
        loc_x = '0;
        loc_y = '0;
        sync_h = 1'b0;
        sync_v = 1'b0;
        mode = 2'd0;
        pause = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_step(1'b0, 1'b0);
        z.chk = 1'b1;
        z.rgb = 8'h00;
        z.hs  = 1'b0;
        z.vs  = 1'b0;
        z.tag = "rstfill";
        for (int k = 0; k < 2; k++) begin
            z.id = k;
            q.push_back(z);
        end
    endtask

    // Probes around every box edge (including overlaps), one random pixel, then a vsync.
    task automatic frame(input logic [1:0] md, input logic pz, input logic [63:0] tag);
        logic [CW-1:0] px, py;
        for (int i = 0; i < NB; i++) begin
            for (int k = 0; k < 5; k++) begin
                case (k)
                    0:       begin px = CW'(mx[i]);          py = CW'(my[i]);          end
                    1:       begin px = CW'(mx[i] + BW - 1); py = CW'(my[i] + BH - 1); end
                    2:       begin px = CW'(mx[i] - 1);      py = CW'(my[i]);          end
                    3:       begin px = CW'(mx[i] + BW);     py = CW'(my[i] + BH / 2); end
                    default: begin px = CW'(mx[i] + BW / 2); py = CW'(my[i] + BH);     end
                endcase
                cycle(1'b1, px, py, 1'b0, 1'b0, md, pz, 1'b1, tag);
            end
        end
        cycle(1'b1, CW'($urandom_range(0, RH - 1)), CW'($urandom_range(0, RV - 1)),
              1'b0, 1'b0, md, pz, 1'b1, tag);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, md, pz, 1'b1, tag);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, md, pz, 1'b1, tag);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, md, pz, 1'b1, tag);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, md, pz, 1'b1, tag);
    endtask

    // Reset-state picture: box0 at (0,0) colour FF, box1 at (80,30) colour 7F.
    task automatic run_table(input logic [63:0] tag);
        vec_t tbl [15];
        exp_t e;
        tbl[0]  = '{1'b1, 13'd10,  13'd10,  1'b0, 2'd0, 8'hFF};
        tbl[1]  = '{1'b1, 13'd10,  13'd10,  1'b1, 2'd0, 8'hFF};
        tbl[2]  = '{1'b1, 13'd90,  13'd40,  1'b0, 2'd0, 8'hFD};
        tbl[3]  = '{1'b1, 13'd31,  13'd23,  1'b0, 2'd0, 8'hFF};
        tbl[4]  = '{1'b1, 13'd32,  13'd10,  1'b0, 2'd0, 8'h00};
        tbl[5]  = '{1'b1, 13'd10,  13'd24,  1'b0, 2'd0, 8'h00};
        tbl[6]  = '{1'b1, 13'd79,  13'd30,  1'b0, 2'd0, 8'h00};
        tbl[7]  = '{1'b1, 13'd80,  13'd30,  1'b0, 2'd0, 8'hFD};
        tbl[8]  = '{1'b1, 13'd111, 13'd53,  1'b0, 2'd0, 8'hFD};
        tbl[9]  = '{1'b1, 13'd112, 13'd40,  1'b0, 2'd0, 8'h00};
        tbl[10] = '{1'b1, 13'd80,  13'd54,  1'b0, 2'd0, 8'h00};
        tbl[11] = '{1'b1, 13'd300, 13'd500, 1'b0, 2'd2, 8'h3D};
        tbl[12] = '{1'b0, 13'd300, 13'd500, 1'b0, 2'd2, 8'h00};
        tbl[13] = '{1'b1, 13'd10,  13'd10,  1'b0, 2'd2, 8'hFF};
        tbl[14] = '{1'b0, 13'd10,  13'd10,  1'b1, 2'd0, 8'h00};
        for (int i = 0; i < 15; i++) begin
            e.chk = 1'b1;
            e.rgb = tbl[i].rgb;
            e.hs  = tbl[i].hs;
            e.vs  = 1'b0;
            e.tag = tag;
            e.id  = i;
            drive_push(tbl[i].img, tbl[i].x, tbl[i].y, tbl[i].hs, 1'b0, tbl[i].md, 1'b0, e);
        end
    endtask

    initial begin
        do_reset();
        run_table("table");

        for (int f = 0; f < 40; f++) frame(2'd0, 1'b0, "move");
        for (int f = 0; f < 3; f++)  frame(2'd2, 1'b1, "pause");
        for (int f = 0; f < 2; f++)  frame(2'd0, 1'b0, "resume");
        for (int f = 0; f < 4; f++)  frame(2'd1, 1'b0, "noise");
        for (int f = 0; f < 3; f++)  frame(2'd3, 1'b0, "nonly");

        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, CW'(mx[0] + k), CW'(my[0] + k), 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, "prerst");
        end
        do_reset();
        run_table("postrst");
        for (int f = 0; f < 5; f++) frame(2'd0, 1'b0, "after");

        cycle(1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "drain");
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
